// File: rtl/up_state_ctrl.sv
// Microprocessor state controller: boot copy from ROM, then run/pause/resume sequencing.
// Optional macro UP_STATE_HLT_PAUSE_EN: a halted core self-pauses from RUN.
module up_state_ctrl #(
  parameter int unsigned BOOT_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_bootData,
  output logic [14:0] o_bootAddr,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memDataOut,
  output logic        o_memWr,
  input  logic        i_pauseReq,
  input  logic        i_coreNowPaused,
  input  logic        i_coreHLT,
  output logic        o_smIsBooted,
  output logic        o_smStartPause,
  output logic        o_reportPaused
);

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StPausing,
    StPaused,
    StResuming
  } stateT;

  localparam logic [14:0] LastAddr = 15'(BOOT_WORDS - 1);

  stateT       state;
  logic [14:0] bootCnt;
  logic        issueDone;
  logic        reqQ;
  logic        reqEdge;
  logic        pauseTrig;

  assign reqEdge    = i_pauseReq & ~reqQ;
  assign o_bootAddr = bootCnt;

`ifdef UP_STATE_HLT_PAUSE_EN
  assign pauseTrig = reqEdge | i_coreHLT;
`else
  logic unusedHlt;
  assign unusedHlt = i_coreHLT;
  assign pauseTrig = reqEdge;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state          <= StBoot;
      bootCnt        <= '0;
      issueDone      <= 1'b0;
      reqQ           <= 1'b0;
      o_memWr        <= 1'b0;
      o_memAddr      <= '0;
      o_memDataOut   <= '0;
      o_smIsBooted   <= 1'b0;
      o_smStartPause <= 1'b0;
      o_reportPaused <= 1'b0;
    end else begin
      reqQ    <= i_pauseReq;
      o_memWr <= 1'b0;
      case (state)
        StBoot: begin
          if (!issueDone) begin
            // Write stage: ROM word for bootCnt is present this cycle.
            o_memWr      <= 1'b1;
            o_memAddr    <= {1'b0, bootCnt};
            o_memDataOut <= i_bootData;
            // Stop on the final count so a full 32768-word copy never relies on wrap.
            if (bootCnt == LastAddr) begin
              issueDone <= 1'b1;
            end else begin
              bootCnt <= bootCnt + 15'd1;
            end
          end else begin
            state        <= StRun;
            o_smIsBooted <= 1'b1;
          end
        end
        StRun: begin
          if (pauseTrig) begin
            state          <= StPausing;
            o_smStartPause <= 1'b1;
          end
        end
        StPausing: begin
          if (i_coreNowPaused) begin
            state          <= StPaused;
            o_reportPaused <= 1'b1;
          end
        end
        StPaused: begin
          if (reqEdge) begin
            state          <= StResuming;
            o_smStartPause <= 1'b0;
            o_reportPaused <= 1'b0;
          end
        end
        StResuming: begin
          if (!i_coreNowPaused) begin
            state <= StRun;
          end
        end
        default: state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_up_state_ctrl.sv
// Self-checking bench for up_state_ctrl: table-driven boot and pause vectors plus
// hand-written reset, long-pause, resume and HLT sequences.
module tb_up_state_ctrl;

  localparam int unsigned BW = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] bootData;
  logic [14:0] bootAddr;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic        memWr;
  logic        pauseReq = 1'b0;
  logic        coreNowPaused;
  logic        coreHLT = 1'b0;
  logic        smIsBooted;
  logic        smStartPause;
  logic        reportPaused;

  int checks = 0;
  int failures = 0;

  logic [15:0] rom [8];

  up_state_ctrl #(
    .BOOT_WORDS(BW)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_bootData     (bootData),
    .o_bootAddr     (bootAddr),
    .o_memAddr      (memAddr),
    .o_memDataOut   (memDataOut),
    .o_memWr        (memWr),
    .i_pauseReq     (pauseReq),
    .i_coreNowPaused(coreNowPaused),
    .i_coreHLT      (coreHLT),
    .o_smIsBooted   (smIsBooted),
    .o_smStartPause (smStartPause),
    .o_reportPaused (reportPaused)
  );

  always #5 clk = ~clk;

  // ROM word for the address presented this cycle, registered by the DUT at the edge.
  always_comb bootData = (bootAddr < 15'd8) ? rom[bootAddr[2:0]] : 16'hDEAD;

  // Core model: confirms the pause command one cycle later.
  always @(posedge clk) begin
    if (!rstn) coreNowPaused <= 1'b0;
    else       coreNowPaused <= smStartPause;
  end

  typedef struct {
    logic        req;
    logic [14:0] bAddr;
    logic        chkAddr;
    logic        wr;
    logic [15:0] mAddr;
    logic [15:0] mData;
    logic        booted;
  } bootVecT;

  typedef struct {
    logic req;
    logic start;
    logic rep;
  } pauseVecT;

  bootVecT  bootTbl  [12];
  pauseVecT pauseTbl [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, ".bootAddr"}, {1'b0, bootAddr}, 16'h0);
    chk({tag, ".memWr"}, {15'd0, memWr}, 16'h0);
    chk({tag, ".memAddr"}, memAddr, 16'h0);
    chk({tag, ".memData"}, memDataOut, 16'h0);
    chk({tag, ".booted"}, {15'd0, smIsBooted}, 16'h0);
    chk({tag, ".start"}, {15'd0, smStartPause}, 16'h0);
    chk({tag, ".rep"}, {15'd0, reportPaused}, 16'h0);
  endtask

  task automatic chkBootRow(input string tag, input int k);
    string n;
    n = $sformatf("%s.c%0d", tag, k);
    if (bootTbl[k].chkAddr) chk({n, ".bootAddr"}, {1'b0, bootAddr}, {1'b0, bootTbl[k].bAddr});
    chk({n, ".memWr"}, {15'd0, memWr}, {15'd0, bootTbl[k].wr});
    chk({n, ".memAddr"}, memAddr, bootTbl[k].mAddr);
    chk({n, ".memData"}, memDataOut, bootTbl[k].mData);
    chk({n, ".booted"}, {15'd0, smIsBooted}, {15'd0, bootTbl[k].booted});
    chk({n, ".start"}, {15'd0, smStartPause}, 16'h0);
  endtask

  // Entered at the negedge inside cycle 0; leaves at the negedge of cycle 12.
  task automatic runBoot(input string tag);
    for (int k = 0; k < 12; k++) begin
      chkBootRow(tag, k);
      pauseReq = bootTbl[k].req;
      @(negedge clk);
    end
    pauseReq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 16'h1111 * 16'(i + 1);

    //             req   bAddr   chkA  wr    mAddr    mData      booted
    bootTbl[0]  = '{1'b0, 15'd0, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0};
    bootTbl[1]  = '{1'b0, 15'd1, 1'b1, 1'b1, 16'd0, 16'h1111, 1'b0};
    bootTbl[2]  = '{1'b0, 15'd2, 1'b1, 1'b1, 16'd1, 16'h2222, 1'b0};
    bootTbl[3]  = '{1'b1, 15'd3, 1'b1, 1'b1, 16'd2, 16'h3333, 1'b0};
    bootTbl[4]  = '{1'b0, 15'd4, 1'b1, 1'b1, 16'd3, 16'h4444, 1'b0};
    bootTbl[5]  = '{1'b0, 15'd5, 1'b1, 1'b1, 16'd4, 16'h5555, 1'b0};
    bootTbl[6]  = '{1'b0, 15'd6, 1'b1, 1'b1, 16'd5, 16'h6666, 1'b0};
    bootTbl[7]  = '{1'b0, 15'd7, 1'b1, 1'b1, 16'd6, 16'h7777, 1'b0};
    bootTbl[8]  = '{1'b0, 15'd0, 1'b0, 1'b1, 16'd7, 16'h8888, 1'b0};
    bootTbl[9]  = '{1'b0, 15'd0, 1'b0, 1'b0, 16'd7, 16'h8888, 1'b1};
    bootTbl[10] = '{1'b0, 15'd0, 1'b0, 1'b0, 16'd7, 16'h8888, 1'b1};
    bootTbl[11] = '{1'b0, 15'd0, 1'b0, 1'b0, 16'd7, 16'h8888, 1'b1};

    //              req   start rep
    pauseTbl[0]  = '{1'b1, 1'b0, 1'b0};  // RUN, edge
    pauseTbl[1]  = '{1'b1, 1'b1, 1'b0};  // PAUSING, level held
    pauseTbl[2]  = '{1'b0, 1'b1, 1'b0};  // PAUSING, core confirms
    pauseTbl[3]  = '{1'b0, 1'b1, 1'b1};  // PAUSED
    pauseTbl[4]  = '{1'b1, 1'b1, 1'b1};  // PAUSED, resume edge
    pauseTbl[5]  = '{1'b0, 1'b0, 1'b0};  // RESUMING, core still paused
    pauseTbl[6]  = '{1'b1, 1'b0, 1'b0};  // RESUMING, edge ignored
    pauseTbl[7]  = '{1'b0, 1'b0, 1'b0};  // RUN
    pauseTbl[8]  = '{1'b0, 1'b0, 1'b0};  // RUN, nothing queued
    pauseTbl[9]  = '{1'b1, 1'b0, 1'b0};  // RUN, edge
    pauseTbl[10] = '{1'b0, 1'b1, 1'b0};  // PAUSING
    pauseTbl[11] = '{1'b1, 1'b1, 1'b0};  // PAUSING, edge ignored
    pauseTbl[12] = '{1'b1, 1'b1, 1'b1};  // PAUSED, held level no edge
    pauseTbl[13] = '{1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chkReset("rst0");
    rstn = 1'b1;
    runBoot("boot1");

    for (int j = 0; j < 14; j++) begin
      chk($sformatf("pause.r%0d.start", j), {15'd0, smStartPause}, {15'd0, pauseTbl[j].start});
      chk($sformatf("pause.r%0d.rep", j), {15'd0, reportPaused}, {15'd0, pauseTbl[j].rep});
      chk($sformatf("pause.r%0d.memWr", j), {15'd0, memWr}, 16'h0);
      chk($sformatf("pause.r%0d.booted", j), {15'd0, smIsBooted}, 16'h1);
      pauseReq = pauseTbl[j].req;
      @(negedge clk);
    end
    pauseReq = 1'b0;

    // Long pause with no pending resume.
    for (int j = 0; j < 100; j++) begin
      if (smStartPause !== 1'b1 || reportPaused !== 1'b1) begin
        chk($sformatf("hold.c%0d.startRep", j), {14'd0, smStartPause, reportPaused}, 16'h3);
      end
      @(negedge clk);
    end
    chk("hold.end.start", {15'd0, smStartPause}, 16'h1);
    chk("hold.end.rep", {15'd0, reportPaused}, 16'h1);
    chk("hold.end.memAddr", memAddr, 16'd7);

    // Resume.
    pauseReq = 1'b1;
    @(negedge clk);
    pauseReq = 1'b0;
    chk("resume.start", {15'd0, smStartPause}, 16'h0);
    chk("resume.rep", {15'd0, reportPaused}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("resume.run.start", {15'd0, smStartPause}, 16'h0);

    // HLT in RUN.
    coreHLT = 1'b1;
    @(negedge clk);
`ifdef UP_STATE_HLT_PAUSE_EN
    chk("hlt.start", {15'd0, smStartPause}, 16'h1);
    coreHLT = 1'b0;
`else
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("hlt.c%0d.start", j), {15'd0, smStartPause}, 16'h0);
      @(negedge clk);
    end
    coreHLT = 1'b0;
    pauseReq = 1'b1;
    @(negedge clk);
    pauseReq = 1'b0;
    chk("postHlt.start", {15'd0, smStartPause}, 16'h1);
`endif

    // Reset while pausing.
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chkReset("rstPause");
    @(negedge clk);

    // Reset mid-boot at cycle 2, then a full restart.
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chkBootRow("abort", k);
      if (k < 2) @(negedge clk);
    end
    rstn = 1'b0;
    @(negedge clk);
    chkReset("rstBoot");
    @(negedge clk);
    rstn = 1'b1;
    runBoot("boot2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
